// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: synchronises rx, qualifies the start bit, samples each bit
// at mid-bit on the 16x oversample strobe and reports the byte via a rdy/clear handshake.
module uart_rx_sampler #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int MID_SAMPLE = 7
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 Rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(MID_SAMPLE);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_s_q;
  logic [1:0]           state_q, state_d;
  logic [SAMP_W-1:0]    sample_q, sample_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q;

    // The acknowledge is honoured on every clock, not just on strobe cycles.
    if (rdy_clr) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    if (Rxclk_en) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d  = S_START;
            sample_d = '0;
          end
        end
        S_START: begin
          if (sample_q == SAMP_MID) begin
            sample_d = '0;
            if (!rx_s_q) begin
              state_d = S_DATA;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            sample_d = sample_q + 1'b1;
          end
        end
        S_DATA: begin
          if (sample_q == SAMP_LAST) begin
            shift_d[bit_q] = rx_s_q;
            sample_d       = '0;
            bit_d          = bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_d = S_STOP;
          end else begin
            sample_d = sample_q + 1'b1;
          end
        end
        default: begin
          if (sample_q == SAMP_LAST) begin
            state_d  = S_IDLE;
            sample_d = '0;
            // A good stop bit takes priority over a coincident acknowledge.
            if (rx_s_q) begin
              data_d = shift_q;
              rdy_d  = 1'b1;
              ferr_d = 1'b0;
              if (rdy_q && !rdy_clr) ovr_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            sample_d = sample_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      sample_q  <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      sample_q  <= sample_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: 50 MHz clock, 1-in-27 oversample strobe, 434-clock bits.
module tb_uart_rx_sampler;

  localparam int BIT_CYC = 434;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       Rxclk_en = 1'b0;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data;
  logic       rdy, frame_err, overrun;

  int cyc = 0;
  int start_cyc = -1;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic       clr;
    logic [7:0] e_data;
    logic       e_rdy;
    logic       e_fe;
    logic       e_ov;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];

  uart_rx_sampler dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .Rxclk_en (Rxclk_en),
    .rx       (rx),
    .rdy_clr  (rdy_clr),
    .data     (data),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #10 clk_50m = ~clk_50m;
  always @(posedge clk_50m) cyc <= cyc + 1;

  initial begin
    int ecnt;
    ecnt = 0;
    forever begin
      @(posedge clk_50m);
      #1;
      ecnt = (ecnt == 26) ? 0 : ecnt + 1;
      Rxclk_en = (ecnt == 26);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk_50m);
    rx = 1'b0;
    start_cyc = cyc;
    idle(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BIT_CYC);
    end
    rx = stop;
    idle(BIT_CYC);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk_50m);
    rdy_clr = 1'b1;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    if (v.clr) pulse_clr();
    sb.push_back(v);
    send_frame(v.din, v.stop);
    idle(BIT_CYC);
    check("sb_nonempty", (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("vec%02h_data", e.din), data, e.e_data);
      check($sformatf("vec%02h_rdy", e.din), rdy, e.e_rdy);
      check($sformatf("vec%02h_frame_err", e.din), frame_err, e.e_fe);
      check($sformatf("vec%02h_overrun", e.din), overrun, e.e_ov);
    end
  endtask

  initial begin
    int lat;
    logic got;

    //            din    stop  clr   data   rdy   fe    ov
    vecs[0] = '{8'hA3, 1'b1, 1'b0, 8'hA3, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h0F, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b1};

    idle(3);
    rst = 1'b0;
    @(negedge clk_50m);
    check("reset_data", data, 8'h00);
    check("reset_rdy", rdy, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    idle(50);

    // 0x55 with latency measurement
    start_cyc = -1;
    got = 1'b0;
    lat = 0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        wait (start_cyc >= 0);
        for (int i = 0; i < 5000 && !got; i++) begin
          @(negedge clk_50m);
          if (rdy) begin
            got = 1'b1;
            lat = cyc - start_cyc;
          end
        end
      end
    join
    check("rdy_rise_seen", got, 1'b1);
    check("rdy_latency_in_window", (lat >= 4096 && lat <= 4152), 1'b1);
    idle(BIT_CYC);
    check("b55_data", data, 8'h55);
    check("b55_rdy", rdy, 1'b1);
    check("b55_frame_err", frame_err, 1'b0);
    check("b55_overrun", overrun, 1'b0);
    pulse_clr();
    check("b55_rdy_cleared", rdy, 1'b0);

    // Start-bit glitch of 3 us
    @(negedge clk_50m);
    rx = 1'b0;
    idle(150);
    rx = 1'b1;
    idle(2 * BIT_CYC);
    check("glitch_rdy", rdy, 1'b0);
    check("glitch_data", data, 8'h55);
    check("glitch_frame_err", frame_err, 1'b0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
      if (i == 4) begin
        pulse_clr();
        check("ovr_clr_rdy", rdy, 1'b0);
        check("ovr_clr_overrun", overrun, 1'b0);
      end
    end

    // Collision: rdy_clr on the stop-sample edge of 0x7E, with rdy=1 and overrun=1
    start_cyc = -1;
    fork
      send_frame(8'h7E, 1'b1);
      begin
        int t0, n;
        wait (start_cyc >= 0);
        t0 = start_cyc;
        n = 0;
        while (cyc < t0 + 2) @(negedge clk_50m);
        for (int k = 0; k < 6000; k++) begin
          if (Rxclk_en) begin
            n++;
            if (n == 153) break;
          end
          @(negedge clk_50m);
        end
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
      end
    join
    idle(BIT_CYC);
    check("collision_rdy", rdy, 1'b1);
    check("collision_data", data, 8'h7E);
    check("collision_overrun", overrun, 1'b0);

    // Reset during data bit 3 of a 0x3C frame, then a clean 0x3C
    @(negedge clk_50m);
    rx = 1'b0;
    idle(BIT_CYC);
    rx = 1'b0; idle(BIT_CYC);
    rx = 1'b0; idle(BIT_CYC);
    rx = 1'b1; idle(BIT_CYC);
    rx = 1'b1; idle(BIT_CYC / 2);
    rst = 1'b1;
    @(negedge clk_50m);
    rst = 1'b0;
    rx = 1'b1;
    @(negedge clk_50m);
    check("midrst_data", data, 8'h00);
    check("midrst_rdy", rdy, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    idle(3 * BIT_CYC);
    run_vec('{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
